// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus bundle: RAM read handshake, IR load strobe,
// decode valid/ready pair and branch redirect.
//   master (fetch_ctrl): drives mem_req, mem_addr, ir_en, instr_valid
//   slave  (memory/IR/decode/branch side): drives mem_ack, instr_ready,
//          redirect, redirect_pc
interface fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic              ir_en;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output mem_req, mem_addr, ir_en, instr_valid,
      input  mem_ack, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, ir_en, instr_valid,
      output mem_ack, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer for the multicycle CPU. Holds the PC, issues
// word reads with req/ack, pulses the IR load enable on returning data and
// offers the latched instruction to decode with valid/ready. Handles branch
// redirects (including ones arriving mid-request) and a bus timeout.
// Ports:
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   start     begin fetching from IDLE / retry from FAULT
//   halt      return to IDLE once the current instruction is handed off
//   bus       fetch_ctrl_if.master (memory, IR, decode, redirect signals)
//   pc        address of the next instruction to fetch
//   busy      controller not idle
//   fault     bus timeout occurred; cleared by start
module fetch_ctrl #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   fetch_ctrl_if.master      bus,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              fault
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_FAULT
   } state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  pc_nxt;
   logic [ADDR_W-1:0]  target, target_nxt;
   logic               discard, discard_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               ir_en_c;
   logic [ADDR_W-1:0]  redir_pc_c;

   // Redirect targets are always word aligned
   assign redir_pc_c = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= ADDR_W'(RESET_PC);
         target  <= '0;
         discard <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         target  <= target_nxt;
         discard <= discard_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // Next-state, datapath updates and IR load strobe
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      target_nxt  = target;
      discard_nxt = discard;
      cnt_nxt     = '0;
      ir_en_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.redirect) pc_nxt = redir_pc_c;
            if (start && !halt) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (bus.mem_ack) begin
               if (discard || bus.redirect) begin
                  // Returning data belongs to the abandoned path; refetch
                  pc_nxt      = bus.redirect ? redir_pc_c : target;
                  discard_nxt = 1'b0;
               end else begin
                  ir_en_c   = 1'b1;
                  pc_nxt    = pc + ADDR_W'(4);
                  state_nxt = S_ISSUE;
               end
            end else begin
               // mem_addr must stay put until ack, so park the target
               if (bus.redirect) begin
                  discard_nxt = 1'b1;
                  target_nxt  = redir_pc_c;
               end
               if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                  state_nxt   = S_FAULT;
                  discard_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_ISSUE: begin
            if (bus.redirect) begin
               pc_nxt    = redir_pc_c;
               state_nxt = S_FETCH;
            end else if (bus.instr_ready) begin
               state_nxt = halt ? S_IDLE : S_FETCH;
            end
         end
         S_FAULT: begin
            if (start) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode straight from the state register so reset clears them at once
   assign bus.mem_req     = (state == S_FETCH);
   assign bus.mem_addr    = pc;
   assign bus.ir_en       = ir_en_c;
   assign bus.instr_valid = (state == S_ISSUE);
   assign busy            = (state != S_IDLE);
   assign fault           = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch, decode stall, redirects in ISSUE
// and mid-request, bus timeout and retry, PC wrap, reset and halt.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        halt;
   logic [31:0] pc;
   logic        busy;
   logic        fault;
   logic [31:0] mem_data;
   logic [31:0] ir;
   int          n_chk  = 0;
   int          n_fail = 0;

   fetch_ctrl_if #(.ADDR_W(32)) bus ();

   fetch_ctrl #(
      .ADDR_W  (32),
      .RESET_PC(0),
      .TIMEOUT (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .halt (halt),
      .bus  (bus),
      .pc   (pc),
      .busy (busy),
      .fault(fault)
   );

   always #5 clk = ~clk;

   // Instruction register fed by the RAM data bus
   always @(posedge clk or posedge rst) begin
      if (rst) ir <= '0;
      else if (bus.ir_en) ir <= mem_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; halt = 1'b0; mem_data = '0;
      bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = '0;
      #12;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_ir_en", 32'(bus.ir_en), 32'd0);
      tick(); rst = 1'b0;

      // 1: basic fetch, ack on third request cycle
      tick(); start = 1'b1; #1;
      chk("t1_idle_req", 32'(bus.mem_req), 32'd0);
      tick(); start = 1'b0; #1;
      chk("t1_req", 32'(bus.mem_req), 32'd1);
      chk("t1_addr", bus.mem_addr, 32'h0);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ir_en_wait", 32'(bus.ir_en), 32'd0);
      tick(); #1;
      chk("t1_addr_hold", bus.mem_addr, 32'h0);
      tick(); bus.mem_ack = 1'b1; mem_data = 32'h00A00093; #1;
      chk("t1_ir_en_ack", 32'(bus.ir_en), 32'd1);
      chk("t1_valid_ack", 32'(bus.instr_valid), 32'd0);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t1_valid", 32'(bus.instr_valid), 32'd1);
      chk("t1_ir_en_off", 32'(bus.ir_en), 32'd0);
      chk("t1_pc", pc, 32'h4);
      chk("t1_ir", ir, 32'h00A00093);
      chk("t1_req_off", 32'(bus.mem_req), 32'd0);

      // 2: decode stalls for 5 cycles, then accepts
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("t2_valid_hold", 32'(bus.instr_valid), 32'd1);
         chk("t2_no_req", 32'(bus.mem_req), 32'd0);
         chk("t2_no_ir_en", 32'(bus.ir_en), 32'd0);
      end
      tick(); bus.instr_ready = 1'b1; #1;
      chk("t2_valid_acc", 32'(bus.instr_valid), 32'd1);
      tick(); bus.instr_ready = 1'b0; bus.mem_ack = 1'b1; mem_data = 32'h11111111; #1;
      chk("t2_req", 32'(bus.mem_req), 32'd1);
      chk("t2_addr", bus.mem_addr, 32'h4);
      chk("t2_valid_off", 32'(bus.instr_valid), 32'd0);
      chk("t2_ir_en", 32'(bus.ir_en), 32'd1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t2_pc", pc, 32'h8);

      // 3: redirect in ISSUE beats ready; misaligned target is aligned
      bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.instr_ready = 1'b1; #1;
      chk("t3_valid", 32'(bus.instr_valid), 32'd1);
      tick(); bus.redirect = 1'b0; bus.instr_ready = 1'b0;
      bus.mem_ack = 1'b1; mem_data = 32'h22222222; #1;
      chk("t3_addr_100", bus.mem_addr, 32'h100);
      chk("t3_valid_off", 32'(bus.instr_valid), 32'd0);
      chk("t3_ir_en", 32'(bus.ir_en), 32'd1);
      tick(); bus.mem_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h203; #1;
      chk("t3_pc", pc, 32'h104);
      tick(); bus.redirect = 1'b0; #1;
      chk("t3_addr_200", bus.mem_addr, 32'h200);
      chk("t3_req", 32'(bus.mem_req), 32'd1);

      // 4: redirect mid-request; stale data dropped, then refetch at target
      bus.redirect = 1'b1; bus.redirect_pc = 32'h300; #1;
      chk("t4_addr_same", bus.mem_addr, 32'h200);
      tick(); bus.redirect = 1'b0; #1;
      chk("t4_addr_hold", bus.mem_addr, 32'h200);
      tick(); bus.mem_ack = 1'b1; mem_data = 32'hDEADBEEF; #1;
      chk("t4_drop_ir_en", 32'(bus.ir_en), 32'd0);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t4_req", 32'(bus.mem_req), 32'd1);
      chk("t4_addr_300", bus.mem_addr, 32'h300);
      chk("t4_ir_kept", ir, 32'h22222222);
      chk("t4_valid_off", 32'(bus.instr_valid), 32'd0);
      tick(); bus.mem_ack = 1'b1; mem_data = 32'h33333333; #1;
      chk("t4_ir_en", 32'(bus.ir_en), 32'd1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t4_pc", pc, 32'h304);
      chk("t4_ir", ir, 32'h33333333);

      // 5: timeout after 4 request cycles, retry at same pc
      bus.instr_ready = 1'b1;
      tick(); bus.instr_ready = 1'b0; #1;
      chk("t5_req1", 32'(bus.mem_req), 32'd1);
      tick(); tick(); tick(); #1;
      chk("t5_req4", 32'(bus.mem_req), 32'd1);
      chk("t5_fault_pre", 32'(fault), 32'd0);
      tick(); #1;
      chk("t5_fault", 32'(fault), 32'd1);
      chk("t5_req_off", 32'(bus.mem_req), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      tick(); #1;
      chk("t5_fault_sticky", 32'(fault), 32'd1);
      start = 1'b1;
      tick(); start = 1'b0; bus.mem_ack = 1'b1; mem_data = 32'h44444444; #1;
      chk("t5_fault_clr", 32'(fault), 32'd0);
      chk("t5_retry_addr", bus.mem_addr, 32'h304);
      chk("t5_retry_ir_en", 32'(bus.ir_en), 32'd1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t5_pc", pc, 32'h308);
      // PC wrap from the top word
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFFFFFC;
      tick(); bus.redirect = 1'b0; bus.mem_ack = 1'b1; mem_data = 32'h55555555; #1;
      chk("t5_wrap_addr", bus.mem_addr, 32'hFFFFFFFC);
      chk("t5_wrap_ir_en", 32'(bus.ir_en), 32'd1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t5_wrap_pc", pc, 32'h0);
      chk("t5_wrap_valid", 32'(bus.instr_valid), 32'd1);

      // 6: halt on handoff, IDLE redirect, async reset in FETCH and ISSUE
      halt = 1'b1; bus.instr_ready = 1'b1;
      tick(); halt = 1'b0; bus.instr_ready = 1'b0; #1;
      chk("t6_halt_busy", 32'(busy), 32'd0);
      chk("t6_halt_req", 32'(bus.mem_req), 32'd0);
      chk("t6_halt_valid", 32'(bus.instr_valid), 32'd0);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
      tick(); bus.redirect = 1'b0; #1;
      chk("t6_idle_redir_pc", pc, 32'h40);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick(); start = 1'b0; #1;
      chk("t6_fetch_addr", bus.mem_addr, 32'h40);
      rst = 1'b1; #1;
      chk("t6_rst_fetch_req", 32'(bus.mem_req), 32'd0);
      chk("t6_rst_fetch_pc", pc, 32'h0);
      chk("t6_rst_fetch_busy", 32'(busy), 32'd0);
      tick(); rst = 1'b0; start = 1'b1;
      tick(); start = 1'b0; bus.mem_ack = 1'b1; mem_data = 32'h66666666; #1;
      chk("t6_refetch_addr", bus.mem_addr, 32'h0);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("t6_issue_valid", 32'(bus.instr_valid), 32'd1);
      chk("t6_issue_pc", pc, 32'h4);
      rst = 1'b1; #1;
      chk("t6_rst_issue_valid", 32'(bus.instr_valid), 32'd0);
      chk("t6_rst_issue_pc", pc, 32'h0);
      tick(); rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
